// File: rtl/fpu_chk_pkg.sv
// Shared types and constants for the FPU result checker: FSM states and
// the widths of the FP16 result, the flag group and the expected-value word.
package fpu_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } chk_state_t;

  localparam int FP16_W = 16;
  localparam int FLAG_N = 3;
  localparam int EXP_W  = FP16_W + FLAG_N;

  localparam logic [FP16_W-1:0] DEFAULT_SENTINEL = 16'hFFFF;

endpackage

// File: rtl/sat_counter.sv
// 8-bit up-counter with synchronous clear that sticks at its maximum value.
module sat_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       inc,
  output logic [7:0] count
);

  localparam logic [7:0] MAX = 8'hFF;

  // Clear wins over increment so a new run always starts from zero.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= 8'd0;
    end else if (inc && (count != MAX)) begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/fpu_result_checker.sv
// Walks an expected-value memory and compares each FPU sample bit-exactly,
// counting mismatches and remembering the address of the first one.
module fpu_result_checker
  import fpu_chk_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter logic [FP16_W-1:0] SENTINEL = DEFAULT_SENTINEL
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [15:0]       result,
  input  logic              underflow,
  input  logic              overflow,
  input  logic              inexact,
  output logic [ADDR_W-1:0] exp_addr,
  input  logic [18:0]       exp_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [7:0]        err_count,
  output logic [ADDR_W-1:0] first_fail_addr,
  output logic              first_fail_valid
);

  chk_state_t state, state_next;

  logic start_run;
  logic sample;
  logic is_sentinel;
  logic compare;
  logic mismatch;
  logic wrap;

  assign start_run   = start && (state != RUN);
  assign sample      = (state == RUN) && in_valid;
  assign is_sentinel = (exp_data[EXP_W-1:FLAG_N] == SENTINEL);
  assign compare     = sample && !is_sentinel;
  assign mismatch    = compare && ({result, underflow, overflow, inexact} != exp_data);
  assign wrap        = compare && (&exp_addr);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start_run) state_next = RUN;
      RUN:  if ((sample && is_sentinel) || wrap) state_next = DONE;
      DONE: if (start_run) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  // Address advances only on real compares, so it wraps to 0 naturally on the last slot.
  always_ff @(posedge clk) begin
    if (reset || start_run) begin
      exp_addr         <= '0;
      first_fail_addr  <= '0;
      first_fail_valid <= 1'b0;
    end else if (compare) begin
      exp_addr <= exp_addr + 1'b1;
      if (mismatch && !first_fail_valid) begin
        first_fail_addr  <= exp_addr;
        first_fail_valid <= 1'b1;
      end
    end
  end

  sat_counter u_err_counter (
    .clk   (clk),
    .reset (reset),
    .clear (start_run),
    .inc   (mismatch),
    .count (err_count)
  );

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign pass = done && (err_count == 8'd0);

endmodule

// File: tb/tb_fpu_result_checker.sv
// Self-checking bench for fpu_result_checker: table-driven runs against a
// behavioural expected-value memory, a scoreboard queue, and corner sequences.
module tb_fpu_result_checker;

  logic        clk;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic [15:0] result;
  logic        underflow;
  logic        overflow;
  logic        inexact;
  logic [7:0]  exp_addr;
  logic [18:0] exp_data;
  logic        busy;
  logic        done;
  logic        pass;
  logic [7:0]  err_count;
  logic [7:0]  first_fail_addr;
  logic        first_fail_valid;

  logic [18:0] exp_mem [256];

  typedef struct {
    logic [15:0] res;
    logic [2:0]  flags;
    logic [18:0] expw;
    logic        sent;
    logic        mis;
  } vec_t;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] err;
    logic       ffv;
    logic [7:0] ffa;
  } exp_t;

  vec_t tbl [10];
  exp_t sb [$];

  int checks = 0;
  int errors = 0;

  fpu_result_checker #(
    .ADDR_W   (8),
    .SENTINEL (16'hFFFF)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .in_valid         (in_valid),
    .result           (result),
    .underflow        (underflow),
    .overflow         (overflow),
    .inexact          (inexact),
    .exp_addr         (exp_addr),
    .exp_data         (exp_data),
    .busy             (busy),
    .done             (done),
    .pass             (pass),
    .err_count        (err_count),
    .first_fail_addr  (first_fail_addr),
    .first_fail_valid (first_fail_valid)
  );

  assign exp_data = exp_mem[exp_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] res, input logic [2:0] flags);
    in_valid  = 1'b1;
    result    = res;
    underflow = flags[2];
    overflow  = flags[1];
    inexact   = flags[0];
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check("sb_exp_addr", 32'(exp_addr), 32'(e.addr));
      check("sb_err_count", 32'(err_count), 32'(e.err));
      check("sb_ff_valid", 32'(first_fail_valid), 32'(e.ffv));
      check("sb_ff_addr", 32'(first_fail_addr), 32'(e.ffa));
    end
  endtask

  task automatic pulseStart();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
    check("start_addr", 32'(exp_addr), 32'd0);
    check("start_err", 32'(err_count), 32'd0);
    check("start_ffv", 32'(first_fail_valid), 32'd0);
  endtask

  // Runs tbl[first +: n] from a fresh start; gap_at < 0 means no idle gap.
  task automatic runTable(input int first, input int n, input int gap_at);
    logic [7:0] a;
    int         e;
    logic       fv;
    logic [7:0] fa;
    vec_t       v;
    for (int i = 0; i < n; i++) exp_mem[i] = tbl[first + i].expw;
    pulseStart();
    a = 8'd0; e = 0; fv = 1'b0; fa = 8'd0;
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) begin
        in_valid = 1'b0;
        result   = 16'hDEAD;
        repeat (5) tick();
        check("gap_addr", 32'(exp_addr), 32'(a));
        check("gap_err", 32'(err_count), 32'(e));
        check("gap_busy", 32'(busy), 32'd1);
      end
      v = tbl[first + i];
      applyStimulus(v.res, v.flags);
      if (!v.sent) begin
        if (v.mis) begin
          if (e < 255) e++;
          if (!fv) begin
            fv = 1'b1;
            fa = a;
          end
        end
        a = a + 8'd1;
      end
      sb.push_back('{addr: a, err: 8'(e), ffv: fv, ffa: fa});
      tick();
      in_valid = 1'b0;
      checkOutput();
    end
    check("run_done", 32'(done), 32'd1);
    check("run_busy", 32'(busy), 32'd0);
    check("run_pass", 32'(pass), (e == 0) ? 32'd1 : 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0;
    result = 16'h0; underflow = 1'b0; overflow = 1'b0; inexact = 1'b0;
    for (int i = 0; i < 256; i++) exp_mem[i] = 19'h0;

    // Clean run: 3 matches then sentinel.
    tbl[0] = '{res: 16'h3C00, flags: 3'b000, expw: {16'h3C00, 3'b000}, sent: 1'b0, mis: 1'b0};
    tbl[1] = '{res: 16'hC500, flags: 3'b001, expw: {16'hC500, 3'b001}, sent: 1'b0, mis: 1'b0};
    tbl[2] = '{res: 16'h0001, flags: 3'b101, expw: {16'h0001, 3'b101}, sent: 1'b0, mis: 1'b0};
    tbl[3] = '{res: 16'h0000, flags: 3'b000, expw: {16'hFFFF, 3'b000}, sent: 1'b1, mis: 1'b0};
    // Failing run: result mismatch at 2, inexact mismatch at 4.
    tbl[4] = '{res: 16'h4000, flags: 3'b000, expw: {16'h4000, 3'b000}, sent: 1'b0, mis: 1'b0};
    tbl[5] = '{res: 16'h7C00, flags: 3'b010, expw: {16'h7C00, 3'b010}, sent: 1'b0, mis: 1'b0};
    tbl[6] = '{res: 16'h3C00, flags: 3'b000, expw: {16'h3C01, 3'b000}, sent: 1'b0, mis: 1'b1};
    tbl[7] = '{res: 16'h8000, flags: 3'b000, expw: {16'h8000, 3'b000}, sent: 1'b0, mis: 1'b0};
    tbl[8] = '{res: 16'h4000, flags: 3'b000, expw: {16'h4000, 3'b001}, sent: 1'b0, mis: 1'b1};
    tbl[9] = '{res: 16'h1234, flags: 3'b111, expw: {16'hFFFF, 3'b011}, sent: 1'b1, mis: 1'b0};

    repeat (2) tick();
    reset = 1'b0;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_pass", 32'(pass), 32'd0);
    check("reset_addr", 32'(exp_addr), 32'd0);
    check("reset_err", 32'(err_count), 32'd0);
    check("reset_ffv", 32'(first_fail_valid), 32'd0);

    // Samples in IDLE are ignored.
    exp_mem[0] = {16'h1111, 3'b000};
    applyStimulus(16'h2222, 3'b111);
    tick();
    in_valid = 1'b0;
    check("idle_sample_addr", 32'(exp_addr), 32'd0);
    check("idle_sample_err", 32'(err_count), 32'd0);
    check("idle_sample_busy", 32'(busy), 32'd0);

    runTable(0, 4, -1);
    check("clean_addr", 32'(exp_addr), 32'd3);

    runTable(0, 4, 2);
    check("gap_final_addr", 32'(exp_addr), 32'd3);

    runTable(4, 6, -1);
    check("fail_err", 32'(err_count), 32'd2);
    check("fail_ffa", 32'(first_fail_addr), 32'd2);
    check("fail_ffv", 32'(first_fail_valid), 32'd1);
    tick();
    check("done_hold_err", 32'(err_count), 32'd2);
    check("done_hold_ffa", 32'(first_fail_addr), 32'd2);

    // Start from DONE with a mismatching sample in the same cycle: sample ignored.
    exp_mem[0] = {16'h1111, 3'b000};
    exp_mem[1] = {16'h2222, 3'b000};
    start = 1'b1;
    applyStimulus(16'h0BAD, 3'b000);
    tick();
    start = 1'b0; in_valid = 1'b0;
    check("restart_busy", 32'(busy), 32'd1);
    check("restart_addr", 32'(exp_addr), 32'd0);
    check("restart_err", 32'(err_count), 32'd0);
    check("restart_ffv", 32'(first_fail_valid), 32'd0);
    applyStimulus(16'h0BAD, 3'b000);
    sb.push_back('{addr: 8'd1, err: 8'd1, ffv: 1'b1, ffa: 8'd0});
    tick();
    in_valid = 1'b0;
    checkOutput();
    // Start during RUN is ignored.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("run_start_addr", 32'(exp_addr), 32'd1);
    check("run_start_err", 32'(err_count), 32'd1);
    check("run_start_busy", 32'(busy), 32'd1);

    // Reset mid-run overrides start and a sample.
    reset = 1'b1; start = 1'b1;
    applyStimulus(16'h0BAD, 3'b000);
    tick();
    reset = 1'b0; start = 1'b0; in_valid = 1'b0;
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_done", 32'(done), 32'd0);
    check("midreset_err", 32'(err_count), 32'd0);
    check("midreset_ffv", 32'(first_fail_valid), 32'd0);
    check("midreset_addr", 32'(exp_addr), 32'd0);
    runTable(0, 4, -1);

    // No sentinel: 256 mismatches wrap the address and saturate the count.
    for (int i = 0; i < 256; i++) exp_mem[i] = 19'h0;
    pulseStart();
    begin
      logic [7:0] a;
      int         e;
      a = 8'd0; e = 0;
      for (int i = 0; i < 256; i++) begin
        applyStimulus(16'h1234, 3'b000);
        if (e < 255) e++;
        a = a + 8'd1;
        sb.push_back('{addr: a, err: 8'(e), ffv: 1'b1, ffa: 8'd0});
        tick();
        in_valid = 1'b0;
        checkOutput();
        if (i < 255) check("sat_still_busy", 32'(busy), 32'd1);
      end
    end
    check("sat_done", 32'(done), 32'd1);
    check("sat_addr", 32'(exp_addr), 32'd0);
    check("sat_err", 32'(err_count), 32'd255);
    check("sat_ffa", 32'(first_fail_addr), 32'd0);
    check("sat_pass", 32'(pass), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL timeout actual=running required=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
